// File: rtl/countdown_sequencer_if.sv
// Control/status bundle between the front-panel controls, the countdown sequencer and the display/alarm logic.
interface countdown_sequencer_if #(
  parameter int WIDTH = 9
);
  logic             start;
  logic             pause;
  logic             clear;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count;
  logic [1:0]       state;
  logic             tick;
  logic             done;
  logic             alarm;

  modport master (
    output start, pause, clear, load_value,
    input  count, state, tick, done, alarm
  );

  modport slave (
    input  start, pause, clear, load_value,
    output count, state, tick, done, alarm
  );
endinterface

// File: rtl/countdown_sequencer.sv
// Countdown timer control FSM with tick prescaler, done pulse and timed alarm.
// Optional COUNTDOWN_AUTO_RELOAD_EN: reload the last started value on expiry instead of alarming.
module countdown_sequencer #(
  parameter int WIDTH       = 9,
  parameter int TICK_DIV    = 50000000,
  parameter int ALARM_TICKS = 8
) (
  input logic                    clock,
  input logic                    reset,
  countdown_sequencer_if.slave   bus
);
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int AW = $clog2(ALARM_TICKS + 1);
  localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSED  = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_count, w_count_next;
  logic [PW-1:0]    r_presc, w_presc_next;
  logic [AW-1:0]    r_alarm_cnt, w_alarm_cnt_next;
  logic             r_done, w_done_next;
  logic             w_tick;
  logic             w_load_ok;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] r_reload, w_reload_next;
`endif

  assign w_tick    = (r_presc == PRESC_MAX) && (r_state == S_RUN || r_state == S_EXPIRED);
  assign w_load_ok = bus.start && (bus.load_value != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_presc     <= '0;
      r_alarm_cnt <= '0;
      r_done      <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      r_reload    <= '0;
`endif
    end else begin
      r_state     <= w_state_next;
      r_count     <= w_count_next;
      r_presc     <= w_presc_next;
      r_alarm_cnt <= w_alarm_cnt_next;
      r_done      <= w_done_next;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      r_reload    <= w_reload_next;
`endif
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_count_next     = r_count;
    w_presc_next     = r_presc;
    w_alarm_cnt_next = r_alarm_cnt;
    w_done_next      = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    w_reload_next    = bus.clear ? '0 : r_reload;
`endif

    if (r_state == S_RUN || r_state == S_EXPIRED) begin
      w_presc_next = w_tick ? '0 : r_presc + PW'(1);
    end

    case (r_state)
      S_IDLE: begin
        w_count_next = '0;
        w_presc_next = '0;
        if (!bus.clear && w_load_ok) begin
          w_count_next = bus.load_value;
          w_state_next = S_RUN;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          w_reload_next = bus.load_value;
`endif
        end
      end

      S_RUN: begin
        if (bus.clear) begin
          w_count_next = '0;
          w_state_next = S_IDLE;
        end else if (w_tick && r_count == WIDTH'(1)) begin
          w_done_next = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          w_count_next = r_reload;
          if (bus.pause) w_state_next = S_PAUSED;
`else
          // Expiry wins over a coincident pause so the timer never parks at zero.
          w_count_next = '0;
          w_state_next = S_EXPIRED;
`endif
        end else begin
          if (w_tick && r_count != '0) w_count_next = r_count - WIDTH'(1);
          if (bus.pause) w_state_next = S_PAUSED;
        end
      end

      S_PAUSED: begin
        if (bus.clear) begin
          w_count_next = '0;
          w_state_next = S_IDLE;
        end else if (bus.start && !bus.pause) begin
          w_state_next = S_RUN;
        end
      end

      S_EXPIRED: begin
        w_count_next = '0;
        if (bus.clear) begin
          w_alarm_cnt_next = '0;
          w_state_next     = S_IDLE;
        end else if (w_load_ok) begin
          w_count_next     = bus.load_value;
          w_presc_next     = '0;
          w_alarm_cnt_next = '0;
          w_state_next     = S_RUN;
        end else if (w_tick) begin
          if (r_alarm_cnt == ALARM_LAST) begin
            w_alarm_cnt_next = '0;
            w_state_next     = S_IDLE;
          end else begin
            w_alarm_cnt_next = r_alarm_cnt + AW'(1);
          end
        end
      end

      default: w_state_next = S_IDLE;
    endcase

    if (w_state_next == S_IDLE) w_presc_next = '0;
  end

  assign bus.count = r_count;
  assign bus.state = r_state;
  assign bus.tick  = w_tick;
  assign bus.done  = r_done;
  assign bus.alarm = (r_state == S_EXPIRED);
endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed bench for countdown_sequencer with TICK_DIV=4, ALARM_TICKS=2.
module tb_countdown_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  countdown_sequencer_if #(.WIDTH(9)) bus ();

  countdown_sequencer #(
    .WIDTH       (9),
    .TICK_DIV    (4),
    .ALARM_TICKS (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-18s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_count"}, 32'(bus.count), 0);
    chk({tag, "_state"}, 32'(bus.state), 0);
    chk({tag, "_tick"},  32'(bus.tick),  0);
    chk({tag, "_done"},  32'(bus.done),  0);
    chk({tag, "_alarm"}, 32'(bus.alarm), 0);
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.pause      = 1'b0;
    bus.clear      = 1'b0;
    bus.load_value = '0;
    cyc();
    cyc();
    reset = 1'b0;
    chk_idle_outputs("por");

    // Reset in the middle of a run
    bus.load_value = 9'd5; bus.start = 1'b1; cyc(); bus.start = 1'b0;
    chk("run5_count", 32'(bus.count), 5);
    cyc(); cyc();
    reset = 1'b1; cyc(); reset = 1'b0;
    chk_idle_outputs("rst_mid");

    // Zero load is ignored; clear and pause in IDLE do nothing
    bus.load_value = 9'd0; bus.start = 1'b1; cyc(); bus.start = 1'b0;
    chk("zero_state", 32'(bus.state), 0);
    chk("zero_count", 32'(bus.count), 0);
    bus.clear = 1'b1; cyc(); bus.clear = 1'b0;
    chk("idle_clr_state", 32'(bus.state), 0);
    bus.pause = 1'b1; cyc(); bus.pause = 1'b0;
    chk("idle_pau_state", 32'(bus.state), 0);
    chk("idle_pau_count", 32'(bus.count), 0);

    // Pause coinciding with a tick, then a mid-period pause
    bus.load_value = 9'd4; bus.start = 1'b1; cyc(); bus.start = 1'b0;
    chk("p_load_count", 32'(bus.count), 4);
    chk("p_load_state", 32'(bus.state), 1);
    cyc(); cyc(); cyc();
    chk("p_tick", 32'(bus.tick), 1);
    bus.pause = 1'b1; cyc(); bus.pause = 1'b0;
    chk("p_pause_count", 32'(bus.count), 3);
    chk("p_pause_state", 32'(bus.state), 2);
    repeat (20) cyc();
    chk("p_hold_count", 32'(bus.count), 3);
    chk("p_hold_state", 32'(bus.state), 2);
    bus.start = 1'b1; bus.pause = 1'b1; cyc();
    chk("p_both_state", 32'(bus.state), 2);
    bus.pause = 1'b0; cyc(); bus.start = 1'b0;
    chk("p_resume_state", 32'(bus.state), 1);
    cyc();
    bus.pause = 1'b1; cyc(); bus.pause = 1'b0;
    chk("p_mid_state", 32'(bus.state), 2);
    repeat (5) cyc();
    chk("p_mid_tick", 32'(bus.tick), 0);
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    chk("p_res2_state", 32'(bus.state), 1);
    chk("p_res2_tick0", 32'(bus.tick), 0);
    cyc();
    chk("p_res2_tick1", 32'(bus.tick), 1);
    cyc();
    chk("p_res2_count", 32'(bus.count), 2);
    bus.clear = 1'b1; cyc(); bus.clear = 1'b0;
    chk("p_clr_state", 32'(bus.state), 0);
    chk("p_clr_count", 32'(bus.count), 0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    // Auto reload: 2,1,2,1,2 with done on each reload
    bus.load_value = 9'd2; bus.start = 1'b1; cyc(); bus.start = 1'b0;
    chk("ar_c0", 32'(bus.count), 2);
    repeat (4) cyc();
    chk("ar_c1", 32'(bus.count), 1);
    repeat (4) cyc();
    chk("ar_c2", 32'(bus.count), 2);
    chk("ar_done1", 32'(bus.done), 1);
    chk("ar_state1", 32'(bus.state), 1);
    chk("ar_alarm1", 32'(bus.alarm), 0);
    cyc();
    chk("ar_done_off", 32'(bus.done), 0);
    repeat (3) cyc();
    chk("ar_c3", 32'(bus.count), 1);
    repeat (4) cyc();
    chk("ar_c4", 32'(bus.count), 2);
    chk("ar_done2", 32'(bus.done), 1);
    chk("ar_state2", 32'(bus.state), 1);
`else
    // Count 3 -> 0, expiry, alarm for 8 cycles
    bus.load_value = 9'd3; bus.start = 1'b1; cyc(); bus.start = 1'b0;
    chk("e_count3", 32'(bus.count), 3);
    chk("e_state_run", 32'(bus.state), 1);
    cyc(); cyc(); cyc();
    chk("e_tick_a", 32'(bus.tick), 1);
    chk("e_count3_held", 32'(bus.count), 3);
    cyc();
    chk("e_count2", 32'(bus.count), 2);
    chk("e_tick_off", 32'(bus.tick), 0);
    repeat (4) cyc();
    chk("e_count1", 32'(bus.count), 1);
    chk("e_done_early", 32'(bus.done), 0);
    repeat (4) cyc();
    chk("e_count0", 32'(bus.count), 0);
    chk("e_state_exp", 32'(bus.state), 3);
    chk("e_done", 32'(bus.done), 1);
    chk("e_alarm", 32'(bus.alarm), 1);
    cyc();
    chk("e_done_off", 32'(bus.done), 0);
    chk("e_state_exp2", 32'(bus.state), 3);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("e_alarm_hold", 32'(bus.alarm), 1);
    end
    cyc();
    chk("e_state_idle", 32'(bus.state), 0);
    chk("e_alarm_off", 32'(bus.alarm), 0);

    // Restart from EXPIRED, ignored start in RUN, clear at count 1
    bus.load_value = 9'd1; bus.start = 1'b1; cyc(); bus.start = 1'b0;
    repeat (4) cyc();
    chk("r_state_exp", 32'(bus.state), 3);
    bus.load_value = 9'd2; bus.start = 1'b1; cyc(); bus.start = 1'b0;
    chk("r_state_run", 32'(bus.state), 1);
    chk("r_count2", 32'(bus.count), 2);
    chk("r_alarm_off", 32'(bus.alarm), 0);
    bus.load_value = 9'd7; bus.start = 1'b1; cyc(); bus.start = 1'b0;
    chk("r_ign_count", 32'(bus.count), 2);
    chk("r_ign_state", 32'(bus.state), 1);
    repeat (3) cyc();
    chk("r_count1", 32'(bus.count), 1);
    bus.clear = 1'b1; cyc(); bus.clear = 1'b0;
    chk("r_clr_state", 32'(bus.state), 0);
    chk("r_clr_count", 32'(bus.count), 0);
    chk("r_clr_done", 32'(bus.done), 0);
    cyc();
    chk("r_clr_done2", 32'(bus.done), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
